// File: rtl/lru_unique_history.sv
// Recency tracker holding up to HISTORY_L pairwise-distinct values, newest in
// slot 0. Each cycle applies an optional invalidate and then an optional insert
// to the current list. Every result, including the hit, eviction and
// invalidate pulses, is registered and appears one cycle after the request.
module lru_unique_history #(
  parameter int DATA_W     = 8,
  parameter int HISTORY_L  = 4,
  parameter int MTF_ON_HIT = 1,
  localparam int CNT_W     = $clog2(HISTORY_L + 1),
  localparam int POS_W     = ($clog2(HISTORY_L) > 0) ? $clog2(HISTORY_L) : 1
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              inv_valid_in,
  input  logic [DATA_W-1:0] inv_data_in,
  output logic [DATA_W-1:0] data_out [HISTORY_L-1:0],
  output logic [HISTORY_L-1:0] valid_out,
  output logic [CNT_W-1:0]  count_out,
  output logic              hit_out,
  output logic [POS_W-1:0]  hit_pos_out,
  output logic              evict_valid_out,
  output logic [DATA_W-1:0] evict_data_out,
  output logic              inv_hit_out
);

  logic [HISTORY_L-1:0] inv_match;
  logic [HISTORY_L-1:0] inv_above;
  logic                 inv_hit;
  logic [DATA_W-1:0]    post_inv_data [HISTORY_L-1:0];
  logic [HISTORY_L-1:0] post_inv_valid;
  logic [CNT_W-1:0]     post_inv_count;

  logic [HISTORY_L-1:0] ins_match;
  logic [HISTORY_L-1:0] ins_cover;
  logic [HISTORY_L-1:0] ins_shift;
  logic                 ins_hit;
  logic                 ins_miss;
  logic [POS_W-1:0]     ins_pos;

  logic [DATA_W-1:0]    next_data [HISTORY_L-1:0];
  logic [HISTORY_L-1:0] next_valid;
  logic [CNT_W-1:0]     next_count;
  logic                 next_evict;
  logic [DATA_W-1:0]    next_evict_data;

  // Invalidate step: locate the matching slot (at most one, since entries are
  // distinct) and close the gap by pulling every slot at or above it down one.
  always_comb begin
    logic run;
    inv_match = '0;
    inv_above = '0;
    run       = 1'b0;
    for (int i = 0; i < HISTORY_L; i++) begin
      inv_match[i] = valid_out[i] && (data_out[i] == inv_data_in);
      run          = run | inv_match[i];
      inv_above[i] = run;
    end
    inv_hit = inv_valid_in && (|inv_match);

    for (int i = 0; i < HISTORY_L - 1; i++) begin
      if (inv_hit && inv_above[i]) begin
        post_inv_data[i]  = data_out[i+1];
        post_inv_valid[i] = valid_out[i+1];
      end else begin
        post_inv_data[i]  = data_out[i];
        post_inv_valid[i] = valid_out[i];
      end
    end
    if (inv_hit) begin
      post_inv_data[HISTORY_L-1]  = '0;
      post_inv_valid[HISTORY_L-1] = 1'b0;
    end else begin
      post_inv_data[HISTORY_L-1]  = data_out[HISTORY_L-1];
      post_inv_valid[HISTORY_L-1] = valid_out[HISTORY_L-1];
    end
    post_inv_count = inv_hit ? (count_out - CNT_W'(1)) : count_out;
  end

  // Insert step on the post-invalidate list: a miss shifts everything up, a hit
  // under move-to-front shifts only the slots at or below the hit position.
  always_comb begin
    logic run;
    ins_match = '0;
    ins_cover = '0;
    ins_shift = '0;
    ins_pos   = '0;
    run       = 1'b0;
    for (int i = 0; i < HISTORY_L; i++) begin
      ins_match[i] = post_inv_valid[i] && (post_inv_data[i] == data_in);
    end
    ins_hit  = valid_in && (|ins_match);
    ins_miss = valid_in && !(|ins_match);

    for (int i = HISTORY_L - 1; i >= 0; i--) begin
      run          = run | ins_match[i];
      ins_cover[i] = run;
    end
    for (int i = 0; i < HISTORY_L; i++) begin
      ins_shift[i] = ins_miss || ((MTF_ON_HIT != 0) && ins_hit && ins_cover[i]);
      if (ins_hit && ins_match[i]) begin
        ins_pos = ins_pos | POS_W'(i);
      end
    end

    next_data[0]  = ins_shift[0] ? data_in : post_inv_data[0];
    next_valid[0] = ins_miss ? 1'b1 : post_inv_valid[0];
    for (int i = 1; i < HISTORY_L; i++) begin
      next_data[i]  = ins_shift[i] ? post_inv_data[i-1] : post_inv_data[i];
      next_valid[i] = ins_miss ? post_inv_valid[i-1] : post_inv_valid[i];
    end

    next_evict      = ins_miss && post_inv_valid[HISTORY_L-1];
    next_evict_data = next_evict ? post_inv_data[HISTORY_L-1] : '0;
    next_count      = (ins_miss && (post_inv_count != CNT_W'(HISTORY_L)))
                      ? (post_inv_count + CNT_W'(1)) : post_inv_count;
  end

  // State and report registers; reset clears everything and overrides requests.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      for (int i = 0; i < HISTORY_L; i++) begin
        data_out[i] <= '0;
      end
      valid_out       <= '0;
      count_out       <= '0;
      hit_out         <= 1'b0;
      hit_pos_out     <= '0;
      evict_valid_out <= 1'b0;
      evict_data_out  <= '0;
      inv_hit_out     <= 1'b0;
    end else begin
      for (int i = 0; i < HISTORY_L; i++) begin
        data_out[i] <= next_data[i];
      end
      valid_out       <= next_valid;
      count_out       <= next_count;
      hit_out         <= ins_hit;
      hit_pos_out     <= ins_pos;
      evict_valid_out <= next_evict;
      evict_data_out  <= next_evict_data;
      inv_hit_out     <= inv_hit;
    end
  end

endmodule

// File: tb/tb_lru_unique_history.sv
// Bench for lru_unique_history: one move-to-front and one keep-order instance
// share the same stimulus and are compared against queue-based models.
module tb_lru_unique_history;

  localparam int DATA_W = 8;
  localparam int HISTORY_L = 4;

  logic clk = 1'b0;
  logic reset_in = 1'b0;
  logic valid_in = 1'b0;
  logic [7:0] data_in = '0;
  logic inv_valid_in = 1'b0;
  logic [7:0] inv_data_in = '0;

  logic [7:0] mtf_data [HISTORY_L-1:0];
  logic [3:0] mtf_valid;
  logic [2:0] mtf_count;
  logic       mtf_hit;
  logic [1:0] mtf_pos;
  logic       mtf_ev;
  logic [7:0] mtf_evd;
  logic       mtf_inv;

  logic [7:0] keep_data [HISTORY_L-1:0];
  logic [3:0] keep_valid;
  logic [2:0] keep_count;
  logic       keep_hit;
  logic [1:0] keep_pos;
  logic       keep_ev;
  logic [7:0] keep_evd;
  logic       keep_inv;

  int test_count = 0;
  int fail_count = 0;

  logic [7:0] q_mtf [$];
  logic [7:0] q_keep [$];
  logic       exp_hit [2];
  int         exp_pos [2];
  logic       exp_ev  [2];
  logic [7:0] exp_evd [2];
  logic       exp_inv [2];

  always #5 clk = ~clk;

  lru_unique_history #(.DATA_W(DATA_W), .HISTORY_L(HISTORY_L), .MTF_ON_HIT(1)) dut_mtf (
    .clk_in(clk), .reset_in(reset_in), .valid_in(valid_in), .data_in(data_in),
    .inv_valid_in(inv_valid_in), .inv_data_in(inv_data_in),
    .data_out(mtf_data), .valid_out(mtf_valid), .count_out(mtf_count),
    .hit_out(mtf_hit), .hit_pos_out(mtf_pos), .evict_valid_out(mtf_ev),
    .evict_data_out(mtf_evd), .inv_hit_out(mtf_inv)
  );

  lru_unique_history #(.DATA_W(DATA_W), .HISTORY_L(HISTORY_L), .MTF_ON_HIT(0)) dut_keep (
    .clk_in(clk), .reset_in(reset_in), .valid_in(valid_in), .data_in(data_in),
    .inv_valid_in(inv_valid_in), .inv_data_in(inv_data_in),
    .data_out(keep_data), .valid_out(keep_valid), .count_out(keep_count),
    .hit_out(keep_hit), .hit_pos_out(keep_pos), .evict_valid_out(keep_ev),
    .evict_data_out(keep_evd), .inv_hit_out(keep_inv)
  );

  // One comparison: counts it, and counts and reports it when it differs.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    test_count++;
    assert (got === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: list as a queue, newest at the front.
  task automatic model_step(input int m, input logic rst, input logic v, input logic [7:0] d,
                            input logic iv, input logic [7:0] id);
    logic [7:0] w [$];
    int idx;
    w = (m == 0) ? q_mtf : q_keep;
    exp_hit[m] = 1'b0; exp_pos[m] = 0; exp_ev[m] = 1'b0; exp_evd[m] = '0; exp_inv[m] = 1'b0;
    if (rst) begin
      w.delete();
    end else begin
      if (iv) begin
        idx = -1;
        foreach (w[i]) if (w[i] == id) idx = i;
        if (idx >= 0) begin
          w.delete(idx);
          exp_inv[m] = 1'b1;
        end
      end
      if (v) begin
        idx = -1;
        foreach (w[i]) if (w[i] == d) idx = i;
        if (idx < 0) begin
          w.push_front(d);
          if (w.size() > HISTORY_L) begin
            exp_evd[m] = w.pop_back();
            exp_ev[m] = 1'b1;
          end
        end else begin
          exp_hit[m] = 1'b1;
          exp_pos[m] = idx;
          if (m == 0 && idx != 0) begin
            w.delete(idx);
            w.push_front(d);
          end
        end
      end
    end
    if (m == 0) q_mtf = w; else q_keep = w;
  endtask

  // Compare every output of one instance with its model.
  task automatic check_output(input int m);
    logic [7:0] d [HISTORY_L];
    logic [3:0] vld;
    logic [2:0] cnt;
    logic hit, ev, inv;
    logic [1:0] pos;
    logic [7:0] evd;
    int sz;
    string pre;
    pre = (m == 0) ? "mtf" : "keep";
    for (int i = 0; i < HISTORY_L; i++) d[i] = (m == 0) ? mtf_data[i] : keep_data[i];
    vld = (m == 0) ? mtf_valid : keep_valid;
    cnt = (m == 0) ? mtf_count : keep_count;
    hit = (m == 0) ? mtf_hit : keep_hit;
    pos = (m == 0) ? mtf_pos : keep_pos;
    ev  = (m == 0) ? mtf_ev : keep_ev;
    evd = (m == 0) ? mtf_evd : keep_evd;
    inv = (m == 0) ? mtf_inv : keep_inv;
    sz  = (m == 0) ? q_mtf.size() : q_keep.size();
    for (int i = 0; i < HISTORY_L; i++) begin
      logic [7:0] e;
      if (i < sz) e = (m == 0) ? q_mtf[i] : q_keep[i];
      else e = 8'h00;
      check_val($sformatf("%s.slot%0d", pre, i), 32'(d[i]), 32'(e));
    end
    check_val({pre, ".valid"}, 32'(vld), (32'd1 << sz) - 32'd1);
    check_val({pre, ".count"}, 32'(cnt), 32'(sz));
    check_val({pre, ".hit"}, 32'(hit), 32'(exp_hit[m]));
    check_val({pre, ".hit_pos"}, 32'(pos), 32'(exp_pos[m]));
    check_val({pre, ".evict"}, 32'(ev), 32'(exp_ev[m]));
    check_val({pre, ".evict_data"}, 32'(evd), 32'(exp_evd[m]));
    check_val({pre, ".inv_hit"}, 32'(inv), 32'(exp_inv[m]));
  endtask

  // Drive one cycle of requests, advance both models and check both DUTs.
  task automatic apply_stimulus(input logic rst, input logic v, input logic [7:0] d,
                                input logic iv, input logic [7:0] id);
    @(negedge clk);
    reset_in = rst; valid_in = v; data_in = d; inv_valid_in = iv; inv_data_in = id;
    model_step(0, rst, v, d, iv, id);
    model_step(1, rst, v, d, iv, id);
    @(posedge clk);
    #1;
    check_output(0);
    check_output(1);
  endtask

  initial begin
    // Reset while an insert is requested; the insert must be ignored.
    apply_stimulus(1'b1, 1'b1, 8'h77, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    // Invalidate on an empty list.
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
    // Fill the list.
    apply_stimulus(1'b0, 1'b1, 8'h11, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b1, 8'h22, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b1, 8'h33, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b1, 8'h44, 1'b0, 8'h00);
    check_val("plan.fill_slot0", 32'(mtf_data[0]), 32'h44);
    // Hit at position 2.
    apply_stimulus(1'b0, 1'b1, 8'h22, 1'b0, 8'h00);
    check_val("plan.mtf_slot0", 32'(mtf_data[0]), 32'h22);
    check_val("plan.keep_slot2", 32'(keep_data[2]), 32'h22);
    // Repeated insert: hit at position 0.
    apply_stimulus(1'b0, 1'b1, 8'h22, 1'b0, 8'h00);
    // Miss on a full list evicts the oldest.
    apply_stimulus(1'b0, 1'b1, 8'h55, 1'b0, 8'h00);
    check_val("plan.evict_data", 32'(mtf_evd), 32'h11);
    // Invalidate hit and miss.
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'h44);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'h99);
    // Same value inserted and invalidated together.
    apply_stimulus(1'b0, 1'b1, 8'h33, 1'b1, 8'h33);
    check_val("plan.same_slot0", 32'(mtf_data[0]), 32'h33);
    // Zero must not match the zero-filled invalid slot.
    apply_stimulus(1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
    check_val("plan.zero_count", 32'(mtf_count), 32'd4);
    // Reset again with an insert pending, then insert after release.
    apply_stimulus(1'b1, 1'b1, 8'h77, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b1, 8'h77, 1'b0, 8'h00);

    // Randomized traffic over a small value range so hits and evictions are common.
    for (int n = 0; n < 400; n++) begin
      apply_stimulus(($urandom_range(0, 49) == 0),
                     1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 6)),
                     1'($urandom_range(0, 2) == 0), 8'($urandom_range(0, 6)));
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/lru_unique_history.md
Name: lru_unique_history

Overview:
- Parametrised successor to the single-shot unique history buffer: keeps up to HISTORY_L pairwise-distinct values, newest-first, packed from slot 0.
- Adds an insert handshake, selectable hit policy (move-to-front or keep order), an explicit invalidate port, and registered hit, eviction and occupancy reporting.
- Used as a recency tracker / small fully-associative tag list in front of replacement logic.

Parameters:
- DATA_W, 8, width of each stored value.
- HISTORY_L, 4, number of entries; must be >= 2.
- MTF_ON_HIT, 1, 1: an insert that hits moves the entry to slot 0; 0: a hit leaves order unchanged.

Ports:
- clk_in  input  1  clock; all state updates on its rising edge.
- reset_in  input  1  synchronous, active-high reset.
- valid_in  input  1  insert request this cycle.
- data_in  input  DATA_W  value to insert.
- inv_valid_in  input  1  invalidate request this cycle.
- inv_data_in  input  DATA_W  value to remove.
- data_out  output  DATA_W x HISTORY_L (unpacked [HISTORY_L-1:0])  stored values; slot 0 is the newest.
- valid_out  output  HISTORY_L  per-slot valid; always a thermometer code from bit 0.
- count_out  output  $clog2(HISTORY_L+1)  number of valid entries.
- hit_out  output  1  registered pulse: the previous-cycle insert matched a valid entry.
- hit_pos_out  output  max(1,$clog2(HISTORY_L))  slot of the match before reordering; 0 when hit_out=0.
- evict_valid_out  output  1  registered pulse: the previous-cycle insert pushed out slot HISTORY_L-1.
- evict_data_out  output  DATA_W  evicted value; 0 when evict_valid_out=0.
- inv_hit_out  output  1  registered pulse: the previous-cycle invalidate removed an entry.

Behaviour:
- Reset (synchronous, active-high, any cycle, overrides all requests):
  - data_out all 0, valid_out 0, count_out 0.
  - hit_out, hit_pos_out, evict_valid_out, evict_data_out and inv_hit_out all 0.
- Invariants:
  - Valid entries are pairwise distinct and contiguous from slot 0.
  - Invalid slots always hold 0.
- All outputs are registered; the effect of a request is visible exactly 1 cycle after it is sampled.
- Pulse outputs are 0 in any cycle that follows no corresponding request.
- Per-cycle processing order:
  1. Invalidate step (only if inv_valid_in), against the current contents:
     - If slot k is valid and equals inv_data_in, slots k+1..HISTORY_L-1 shift down one place.
     - The top slot clears to 0 / invalid, count decrements, inv_hit_out=1.
     - Otherwise no change and inv_hit_out=0.
  2. Insert step (only if valid_in), against the post-invalidate list:
     - Match search: compare data_in with every valid slot (all HISTORY_L slots; no hard-coded limit).
     - Miss: slots 0..HISTORY_L-2 shift up, data_in goes to slot 0, count increments, saturating at HISTORY_L.
       - If the list was full, the old slot HISTORY_L-1 drops out: evict_valid_out=1, evict_data_out=that value.
     - Hit at slot p: hit_out=1, hit_pos_out=p, count unchanged, no eviction.
       - MTF_ON_HIT=1: slots 0..p-1 shift up and data_in goes to slot 0.
       - MTF_ON_HIT=0: no change.
       - p=0: no change in either mode.
- Simultaneous insert and invalidate of the same value:
  - The invalidate removes the entry; the insert then misses and re-adds it at slot 0.
  - Result: inv_hit_out=1, hit_out=0, count unchanged.
- Insert on an empty list: miss, value lands in slot 0, count 1.
- Invalidate on an empty list: no-op, inv_hit_out=0.
- Consecutive inserts of the same value: first is a miss, each later one is a hit at pos 0 with no state change.
- Match detection is a one-hot vector over valid slots, guaranteed by the invariant.
- hit_pos_out is the encoded index of the match; invalid slots never match, even when data_in equals 0.

Test Plan:
- Reset, insert 0x11,0x22,0x33,0x44 on consecutive cycles -> data_out={0x44,0x33,0x22,0x11} (slot0 first), valid_out=4'b1111, count_out=4; hit_out and evict_valid_out stay 0.
- From that state, insert 0x22:
  - MTF_ON_HIT=1 -> hit_out=1, hit_pos_out=2, data_out={0x22,0x44,0x33,0x11}.
  - MTF_ON_HIT=0 -> hit_out=1, hit_pos_out=2, order unchanged.
- Then (MTF=1) insert 0x55 -> evict_valid_out=1, evict_data_out=0x11, data_out={0x55,0x22,0x44,0x33}, count_out=4.
- Invalidate 0x44 -> inv_hit_out=1, data_out={0x55,0x22,0x33,0}, valid_out=4'b0111, count_out=3; then invalidate 0x99 -> inv_hit_out=0, no change.
- Same cycle: insert 0x33 and invalidate 0x33 -> inv_hit_out=1, hit_out=0, data_out={0x33,0x55,0x22,0}, count_out=3; then insert 0x00 with 0 in invalid slot 3 -> miss, count_out=4.
- Assert reset_in while valid_in=1 with data 0x77 -> next cycle all outputs 0, count_out=0; insert 0x77 after release -> slot0=0x77, hit_out=0.
